// File: rtl/ps2_keyboard_rx_pkg.sv
// Shared PS/2 receiver types and keyboard scan-code constants, also used by the game FSM.
package ps2_keyboard_rx_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity,
    StStop
  } ps2_state_e;

  localparam int unsigned PS2_FRAME_BITS = 11;
  localparam int unsigned PS2_DATA_BITS  = 8;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_ESC   = 8'h76;
  localparam logic [7:0] SC_1     = 8'h16;
  localparam logic [7:0] SC_2     = 8'h1E;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_J     = 8'h3B;
  localparam logic [7:0] SC_L     = 8'h4B;

  // True when data plus parity bit carry an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_keyboard_rx_clk_filter.sv
// Two-flop synchronizers for ps2_clk/ps2_data plus a glitch filter on ps2_clk;
// emits a registered one-cycle strobe on each filtered falling edge with the data sample.
module ps2_clk_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic bit_event,
  output logic bit_data
);

  localparam int unsigned CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(FILTER_LEN - 1);

  logic [1:0]    clk_sync_q, data_sync_q;
  logic          filt_q, filt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          event_q, data_q;

  // cnt counts consecutive samples that disagree with the filtered level.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (clk_sync_q[1] != filt_q) begin
      if (cnt_q == LAST_CNT) begin
        filt_d = clk_sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clk_sync_q  <= '0;
      data_sync_q <= '0;
      filt_q      <= 1'b1;
      cnt_q       <= '0;
      event_q     <= 1'b0;
      data_q      <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk};
      data_sync_q <= {data_sync_q[0], ps2_data};
      filt_q      <= filt_d;
      cnt_q       <= cnt_d;
      event_q     <= filt_q & ~filt_d;
      data_q      <= data_sync_q[1];
    end
  end

  assign bit_event = event_q;
  assign bit_data  = data_q;

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard frame receiver: start, 8 data LSB first, odd parity, stop, with idle timeout.
// Optional macro PS2_BREAK_FILTER_EN hides 8'hF0 and the byte that follows it.
module ps2_keyboard_rx
  import ps2_keyboard_rx_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned FILTER_LEN     = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] tasta,
  output logic       done,
  output logic       frame_err
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO = TW'(TIMEOUT_CYCLES);
  localparam logic [2:0] LAST_BIT = 3'(PS2_DATA_BITS - 1);

  logic bit_event, bit_data;

  ps2_clk_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_clk_filter (
    .clock    (clock),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .bit_event(bit_event),
    .bit_data (bit_data)
  );

  ps2_state_e    state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_ok_q, par_ok_d;
  logic [7:0]    tasta_q, tasta_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          timeout;
`ifdef PS2_BREAK_FILTER_EN
  logic          brk_q, brk_d;
`endif

  assign timeout = (state_q != StIdle) && (tcnt_q == TMO);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_ok_d  = par_ok_q;
    tasta_d   = tasta_q;
    done_d    = done_q;
    err_d     = 1'b0;
    tcnt_d    = '0;
`ifdef PS2_BREAK_FILTER_EN
    brk_d     = brk_q;
`endif

    if (state_q != StIdle) begin
      tcnt_d = bit_event ? '0 : tcnt_q + 1'b1;
    end

    // Timeout wins over a coincident bit event.
    if (timeout) begin
      state_d   = StIdle;
      shift_d   = '0;
      bit_cnt_d = '0;
      err_d     = 1'b1;
      tcnt_d    = '0;
`ifdef PS2_BREAK_FILTER_EN
      brk_d     = 1'b0;
`endif
    end else if (bit_event) begin
      unique case (state_q)
        StIdle: begin
          if (!bit_data) begin
            state_d   = StData;
            bit_cnt_d = '0;
            done_d    = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
        StData: begin
          shift_d = {bit_data, shift_q[7:1]};
          if (bit_cnt_q == LAST_BIT) begin
            state_d = StParity;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        StParity: begin
          par_ok_d = odd_parity_ok(shift_q, bit_data);
          state_d  = StStop;
        end
        StStop: begin
          state_d = StIdle;
          if (bit_data && par_ok_q) begin
`ifdef PS2_BREAK_FILTER_EN
            if (brk_q) begin
              brk_d = 1'b0;
            end else if (shift_q == SC_BREAK) begin
              brk_d = 1'b1;
            end else begin
              tasta_d = shift_q;
              done_d  = 1'b1;
            end
`else
            tasta_d = shift_q;
            done_d  = 1'b1;
`endif
          end else begin
            err_d = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_ok_q  <= 1'b0;
      tasta_q   <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      tcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_ok_q  <= par_ok_d;
      tasta_q   <= tasta_d;
      done_q    <= done_d;
      err_q     <= err_d;
      tcnt_q    <= tcnt_d;
    end
  end

`ifdef PS2_BREAK_FILTER_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      brk_q <= 1'b0;
    end else begin
      brk_q <= brk_d;
    end
  end
`endif

  assign tasta     = tasta_q;
  assign done      = done_q;
  assign frame_err = err_q;

endmodule

// File: doc/ps2_keyboard_rx.md
PS2_KEYBOARD_RX -- requirements
Module: ps2_keyboard_rx

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 50000, idle-gap limit in clock cycles (1 ms at 50 MHz) before a partial frame is discarded.
REQ-002 SHALL have parameter FILTER_LEN, default 8, number of consecutive equal synchronized ps2_clk samples required to accept a level change.
REQ-003 SHALL have port clock  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous active-low reset.
REQ-005 SHALL have port ps2_clk  input  1  raw PS/2 clock from keyboard, asynchronous.
REQ-006 SHALL have port ps2_data  input  1  raw PS/2 data from keyboard, asynchronous.
REQ-007 SHALL have port tasta  output  8  last accepted scan code.
REQ-008 SHALL have port done  output  1  level; high while tasta holds a new valid code.
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse on parity, start or stop error, or timeout.

Function
REQ-010 SHALL pass ps2_clk and ps2_data through two-flop synchronizers.
REQ-011 SHALL debounce synchronized ps2_clk: filtered level changes only after FILTER_LEN identical samples.
REQ-012 SHALL define a bit event as a 1->0 transition of filtered ps2_clk; ps2_data is sampled in the same cycle.
REQ-013 SHALL use states IDLE, DATA, PARITY, STOP.
REQ-014 IDLE: a bit event with data=0 SHALL go to DATA, clear the bit counter, and drive done low; a bit event with data=1 SHALL stay in IDLE and pulse frame_err.
REQ-015 DATA: SHALL shift data in LSB first on each bit event; after the 8th bit SHALL go to PARITY (3-bit counter, no wrap beyond 7).
REQ-016 PARITY: SHALL capture the bit; odd parity over 8 data bits plus parity SHALL be required; SHALL go to STOP.
REQ-017 STOP: on a bit event SHALL return to IDLE; if data=1 and parity was good, SHALL load tasta and set done in the next clock cycle; otherwise SHALL pulse frame_err and leave tasta/done unchanged.
REQ-018 Outside IDLE, a cycle counter SHALL reset on each bit event; reaching TIMEOUT_CYCLES SHALL force IDLE, discard the partial byte, and pulse frame_err.
REQ-019 done SHALL stay high until the start bit of the next frame (REQ-014) or reset; tasta SHALL hold its value until the next valid frame.
REQ-020 A bit event in the same cycle as the timeout SHALL be treated as a timeout, with the event ignored.

Reset
REQ-021 On reset low: state IDLE; tasta=8'h00, done=0, frame_err=0; counters, shift register and synchronizers cleared; filtered clock=1.
REQ-022 Reset mid-frame SHALL discard the frame; the first valid frame after release SHALL be received normally.

Configuration
REQ-023 With PS2_BREAK_FILTER_EN defined: a valid byte 8'hF0 SHALL NOT assert done, and the following valid byte SHALL also be suppressed (release codes hidden); a suppression flag clears on that byte, timeout, or reset.
REQ-024 Without PS2_BREAK_FILTER_EN: every valid byte, including 8'hF0, SHALL assert done.

Structure
REQ-025 A shared package SHALL hold the state enumeration, the PS/2 frame constants (11 bits, 8 data), and scan-code constants (8'hF0, 8'h29 SPACE, 8'h76 ESC, 8'h16 '1', 8'h1E '2', 8'h1C A, 8'h23 D, 8'h3B J, 8'h4B L) shared with the game FSM.
REQ-026 The synchronizer plus debounce filter SHALL be one sub-module, ps2_clk_filter, outputting the bit-event strobe.

Verification
REQ-027 Send 0x1C, parity 0, stop 1 -> tasta=8'h1C; done rises one cycle after the 11th event; frame_err stays 0.
REQ-028 Send 0x29, then 0x76 -> done falls at the second start bit and rises again with tasta=8'h76.
REQ-029 Send 0x16 with parity 1 -> one frame_err pulse; tasta and done keep their prior values.
REQ-030 Send 5 bits, stall TIMEOUT_CYCLES+1 cycles -> frame_err pulse and state IDLE; next frame 0x1E is received correctly.
REQ-031 Send 0xF0 then 0x1C -> with PS2_BREAK_FILTER_EN, done never rises; without it, tasta=8'hF0 then 8'h1C.
REQ-032 Assert reset after 6 bits of 0x23, release, send 0x4B -> all outputs zero during reset; then tasta=8'h4B, done=1.
